// File: rtl/hs32_pkg.sv
// Shared constants for the hs32 fetch stage: state encodings, word size, PC step.
package hs32_pkg;

  localparam int unsigned HS32_WORD      = 32;
  localparam int unsigned HS32_INST_STEP = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  function automatic logic [HS32_WORD-1:0] hs32_align(input logic [HS32_WORD-1:0] a);
    return {a[HS32_WORD-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/hs32_fifo.sv
// Small synchronous FIFO; clear wins over push/pop, push+pop allowed when full.
module hs32_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[PW'(i)] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch: single-outstanding memory reads into a PC-tagged
// prefetch FIFO, presented to decode; flush redirects and discards in-flight work.
module hs32_fetch
  import hs32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  output logic        reqm,
  input  logic        ackm,
  input  logic [31:0] dtr,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic        reqd,
  input  logic        ackd,
  input  logic [31:0] newpc,
  input  logic        flush
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]    state, state_n;
  logic [31:0]   pc, pc_n, addr_n, pc_inc, target;
  logic          reqm_n;
  logic          push, pop, fifo_empty;
  logic [CW-1:0] fifo_count, count_after;
  logic [63:0]   head;
  logic          space_now, space_after;

  assign target      = hs32_align(newpc);
  assign pc_inc      = pc + 32'(HS32_INST_STEP);
  assign push        = reqm && (state == ST_REQ) && ackm && !flush;
  assign pop         = !fifo_empty && ackd && !flush;
  assign count_after = fifo_count + CW'(push) - CW'(pop);
  assign space_now   = fifo_count < CW'(FIFO_DEPTH);
  assign space_after = count_after < CW'(FIFO_DEPTH);

  hs32_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata ({pc, dtr}),
    .rdata (head),
    .full  (),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign reqd  = !fifo_empty;
  assign pcd   = head[63:32];
  assign instd = head[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
      reqm  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
      reqm  <= reqm_n;
    end
  end

  // In REQ the outstanding address always equals pc, so pushes tag with pc.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = addr;
    reqm_n  = reqm;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          pc_n    = target;
          addr_n  = target;
          reqm_n  = 1'b1;
          state_n = ST_REQ;
        end else if (space_now) begin
          addr_n  = pc;
          reqm_n  = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ackm && flush) begin
          pc_n   = target;
          addr_n = target;
        end else if (flush) begin
          pc_n    = target;
          state_n = ST_DROP;
        end else if (ackm) begin
          pc_n = pc_inc;
          if (space_after) begin
            addr_n = pc_inc;
          end else begin
            reqm_n  = 1'b0;
            state_n = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (flush) pc_n = target;
        if (ackm) begin
          addr_n  = flush ? target : pc;
          state_n = ST_REQ;
        end
      end
      default: begin
        reqm_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hs32_fetch.sv
// Self-checking bench for hs32_fetch: directed vector table, reset corner case,
// and randomized traffic against a queue-based fetch model.
module tb_hs32_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam logic [31:0] K          = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, dtr, instd, pcd, newpc;
  logic        reqm, ackm, reqd, ackd, flush;

  int vectors = 0;
  int miscompares = 0;

  hs32_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .reqm  (reqm),
    .ackm  (ackm),
    .dtr   (dtr),
    .instd (instd),
    .pcd   (pcd),
    .reqd  (reqd),
    .ackd  (ackd),
    .newpc (newpc),
    .flush (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ackm, ackd, flush;
    logic [31:0] newpc;
    logic        e_reqm;
    logic [31:0] e_addr;
    logic        chk_addr;
    logic        e_reqd;
    logic [31:0] e_pcd;
  } vec_t;

  vec_t tbl[21];

  typedef struct packed { logic [31:0] pc; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic        m_reqm;
  logic [31:0] m_addr, fpc;
  bit          doomed;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic row(input int i, input logic am, input logic ad, input logic fl,
                     input logic [31:0] np, input logic er, input logic [31:0] ea,
                     input logic ca, input logic ed, input logic [31:0] ep);
    tbl[i] = '{am, ad, fl, np, er, ea, ca, ed, ep};
  endtask

  task automatic do_reset();
    reset = 1'b1; ackm = 0; ackd = 0; flush = 0; newpc = '0; dtr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_reqm", 32'(reqm), 32'd0);
    check("rst_reqd", 32'(reqd), 32'd0);
    check("rst_addr", addr, RESET_PC);
    check("rst_instd", instd, 32'd0);
    check("rst_pcd", pcd, 32'd0);
    reset = 1'b0;
  endtask

  // Fetch model: FIFO as a queue, an outstanding request and a flag marking it stale.
  task automatic model_step(input logic fl, input logic [31:0] np, input logic am,
                            input logic ad, input logic [31:0] d);
    int sz0 = q.size();
    bit ack = m_reqm && am;
    if (fl) begin
      q.delete();
      fpc = {np[31:2], 2'b00};
      if (ack || !m_reqm) begin
        m_reqm = 1; m_addr = fpc; doomed = 0;
      end else doomed = 1;
    end else begin
      if (sz0 > 0 && ad) void'(q.pop_front());
      if (ack && doomed) begin
        doomed = 0; m_addr = fpc;
      end else if (ack) begin
        q.push_back({m_addr, d});
        fpc = m_addr + 32'd4;
        if (q.size() < FIFO_DEPTH) m_addr = fpc;
        else m_reqm = 0;
      end else if (!m_reqm && sz0 < FIFO_DEPTH) begin
        m_reqm = 1; m_addr = fpc;
      end
    end
  endtask

  initial begin
    row(0,  1,0,0,32'h0,         1,32'h0,         1, 0,32'h0);
    row(1,  1,0,0,32'h0,         1,32'h4,         1, 1,32'h0);
    row(2,  1,0,0,32'h0,         0,32'h0,         0, 1,32'h0);
    row(3,  1,0,0,32'h0,         0,32'h0,         0, 1,32'h0);
    row(4,  0,1,0,32'h0,         0,32'h0,         0, 1,32'h4);
    row(5,  0,0,0,32'h0,         1,32'h8,         1, 1,32'h4);
    row(6,  1,1,0,32'h0,         1,32'hC,         1, 1,32'h8);
    row(7,  0,0,1,32'hFFFF_FFFB, 1,32'hC,         1, 0,32'h0);
    row(8,  0,0,0,32'h0,         1,32'hC,         1, 0,32'h0);
    row(9,  1,0,0,32'h0,         1,32'hFFFF_FFF8, 1, 0,32'h0);
    row(10, 1,1,0,32'h0,         1,32'hFFFF_FFFC, 1, 1,32'hFFFF_FFF8);
    row(11, 1,1,0,32'h0,         1,32'h0,         1, 1,32'hFFFF_FFFC);
    row(12, 1,1,0,32'h0,         1,32'h4,         1, 1,32'h0);
    row(13, 1,1,1,32'h100,       1,32'h100,       1, 0,32'h0);
    row(14, 1,1,0,32'h0,         1,32'h104,       1, 1,32'h100);
    row(15, 0,0,0,32'h0,         1,32'h104,       1, 1,32'h100);
    row(16, 0,1,0,32'h0,         1,32'h104,       1, 0,32'h0);
    row(17, 1,0,0,32'h0,         1,32'h108,       1, 1,32'h104);
    row(18, 1,0,0,32'h0,         0,32'h0,         0, 1,32'h104);
    row(19, 0,1,1,32'h203,       1,32'h200,       1, 0,32'h0);
    row(20, 1,0,0,32'h0,         1,32'h204,       1, 1,32'h200);

    // Directed table; memory returns addr ^ K.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      ackm = tbl[i].ackm; ackd = tbl[i].ackd; flush = tbl[i].flush;
      newpc = tbl[i].newpc; dtr = addr ^ K;
      @(posedge clk); #1;
      check($sformatf("t%0d_reqm", i), 32'(reqm), 32'(tbl[i].e_reqm));
      if (tbl[i].chk_addr) check($sformatf("t%0d_addr", i), addr, tbl[i].e_addr);
      check($sformatf("t%0d_reqd", i), 32'(reqd), 32'(tbl[i].e_reqd));
      if (tbl[i].e_reqd) begin
        check($sformatf("t%0d_pcd", i), pcd, tbl[i].e_pcd);
        check($sformatf("t%0d_instd", i), instd, tbl[i].e_pcd ^ K);
      end
    end

    // Reset asserted mid-wait with a buffered word; late ackm under reset ignored.
    do_reset();
    @(posedge clk); #1;
    check("mr_reqm0", 32'(reqm), 32'd1);
    ackm = 1; dtr = 32'h1111_2222;
    @(posedge clk); #1;
    check("mr_reqd0", 32'(reqd), 32'd1);
    ackm = 0;
    @(posedge clk); #1;
    check("mr_wait_reqm", 32'(reqm), 32'd1);
    check("mr_wait_addr", addr, 32'h4);
    #2 reset = 1; ackm = 1; dtr = 32'hDEAD_BEEF;
    #1;
    check("mr_async_reqm", 32'(reqm), 32'd0);
    check("mr_async_reqd", 32'(reqd), 32'd0);
    check("mr_async_addr", addr, RESET_PC);
    @(posedge clk); #1;
    check("mr_held_reqm", 32'(reqm), 32'd0);
    reset = 0; ackm = 0;
    @(posedge clk); #1;
    check("mr_rel_reqm", 32'(reqm), 32'd1);
    check("mr_rel_addr", addr, RESET_PC);
    check("mr_rel_reqd", 32'(reqd), 32'd0);
    ackm = 1; dtr = 32'h1234_5678;
    @(posedge clk); #1;
    check("mr_first_reqd", 32'(reqd), 32'd1);
    check("mr_first_pcd", pcd, RESET_PC);
    check("mr_first_instd", instd, 32'h1234_5678);

    // Randomized traffic against the model.
    do_reset();
    q.delete(); m_reqm = 0; m_addr = RESET_PC; fpc = RESET_PC; doomed = 0;
    for (int c = 0; c < 3000; c++) begin
      int ack_pct = 20 + 30 * ((c / 250) % 3);
      ackm  = ($urandom_range(99) < ack_pct + 10);
      ackd  = ($urandom_range(99) < ack_pct);
      flush = !flush && ($urandom_range(24) == 0);
      newpc = $urandom;
      dtr   = $urandom;
      @(posedge clk);
      model_step(flush, newpc, ackm, ackd, dtr);
      #1;
      check("rnd_reqm", 32'(reqm), 32'(m_reqm));
      if (m_reqm) check("rnd_addr", addr, m_addr);
      check("rnd_reqd", 32'(reqd), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("rnd_pcd", pcd, q[0].pc);
        check("rnd_instd", instd, q[0].d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
